// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end: issues sequential word fetches to instruction
// memory, tracks in-flight requests, buffers returned instructions with their
// PCs in a small FIFO for decode, and handles redirects by flushing the FIFO
// and discarding every response still in flight.
//
// Parameters:
//   XLEN         width of PC, addresses and instruction word
//   RESET_VECTOR PC loaded on reset
//   FIFO_DEPTH   instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   redirect_valid, redirect_target  change fetch PC, flush buffered work
//   imem_req_valid/addr/ready        memory request handshake
//   imem_rsp_valid/data              in-order memory responses
//   if_valid/instr/pc, if_ready      decode handshake (FIFO head)
//   misalign_fault                   one-cycle pulse on misaligned redirect
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  defined: a misaligned redirect pulses
//   misalign_fault and halts fetch until the next aligned redirect.
//   Undefined: the low two target bits are cleared and the fault is tied low.
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready,
    output logic            misalign_fault
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;       // PC of the next response that will be kept
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    cnt_t            fifo_count;
    cnt_t            outstanding;  // all requests in flight, kept or dropped
    cnt_t            drop_count;   // leading in-flight responses to discard

    logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];

    logic [XLEN-1:0] target;
    logic            halted;

    logic            req_fire;
    logic            push;
    logic            pop;
    logic            rsp_drop;
    logic [CW:0]     in_flight;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic target_bad;

    assign target     = redirect_target;
    assign target_bad = redirect_target[1:0] != 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted         <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            misalign_fault <= redirect_valid && target_bad;
            if (redirect_valid) begin
                halted <= target_bad;
            end
        end
    end
`else
    assign target         = redirect_target & ~XLEN'(3);
    assign halted         = 1'b0;
    assign misalign_fault = 1'b0;
`endif

    assign if_valid      = fifo_count != '0;
    assign if_instr      = fifo_instr[rd_ptr];
    assign if_pc         = fifo_pc[rd_ptr];
    assign imem_req_addr = fetch_pc;

    // Requests are throttled so that every in-flight response is guaranteed
    // a FIFO slot; this is what makes overflow impossible.
    always_comb begin
        in_flight      = {1'b0, fifo_count} + {1'b0, outstanding};
        imem_req_valid = !reset && !redirect_valid && !halted &&
                         (drop_count == '0) &&
                         (in_flight < (CW+1)'(FIFO_DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_count != '0);
        push           = imem_rsp_valid && (drop_count == '0) && !redirect_valid;
        pop            = if_valid && if_ready && !redirect_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_count  <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle's response is stale,
            // including responses already marked for dropping.
            fetch_pc    <= target;
            rsp_pc      <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= outstanding - cnt_t'(imem_rsp_valid);
            drop_count  <= outstanding - cnt_t'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (rsp_drop) begin
                drop_count <= drop_count - cnt_t'(1);
            end
            fifo_count  <= fifo_count + cnt_t'(push) - cnt_t'(pop);
            outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, width of PC, addresses and instruction word.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter FIFO_DEPTH, default 4, instruction buffer entries; power of two, at least 2.
REQ-004 Ports: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-005 Redirect ports: redirect_valid in 1 redirect request; redirect_target in XLEN new fetch PC.
REQ-006 Memory request ports: imem_req_valid out 1 request; imem_req_addr out XLEN request address; imem_req_ready in 1 memory accepts.
REQ-007 Memory response ports: imem_rsp_valid in 1 response; imem_rsp_data in XLEN instruction; responses return in request order.
REQ-008 Decode ports: if_valid out 1 entry available; if_instr out XLEN instruction; if_pc out XLEN instruction address; if_ready in 1 decode consumes.
REQ-009 Fault port: misalign_fault out 1 misaligned-redirect pulse.

Function
REQ-010 fetch_pc SHALL advance by 4 on each accepted request (imem_req_valid && imem_req_ready), wrapping modulo 2^XLEN.
REQ-011 imem_req_addr SHALL equal fetch_pc; imem_req_valid SHALL be high only when (fifo_count + outstanding) < FIFO_DEPTH and no drop is pending.
REQ-012 outstanding SHALL increment on accepted request, decrement on imem_rsp_valid, and be unchanged when both occur in the same cycle.
REQ-013 Each non-dropped response SHALL be written to the FIFO with its request PC; the FIFO SHALL never overflow.
REQ-014 if_valid SHALL equal FIFO not empty; if_instr/if_pc SHALL show the head entry; the head is popped when if_valid && if_ready.
REQ-015 Simultaneous push and pop SHALL leave fifo_count unchanged; a push into an empty FIFO SHALL appear on if_valid the next cycle (1-cycle response-to-decode latency).
REQ-016 On redirect_valid: fetch_pc <= redirect_target; FIFO flushed (fifo_count <= 0); drop_count <= outstanding minus any response arriving that cycle; no request is issued that cycle.
REQ-017 While drop_count != 0, each imem_rsp_valid SHALL be discarded and decrement drop_count; new requests resume when drop_count reaches 0.
REQ-018 redirect_valid SHALL take priority over a same-cycle pop, push or request acceptance.
REQ-019 A redirect while drop_count != 0 SHALL add remaining outstanding to drop_count correctly (no stale response ever reaches the FIFO).
REQ-020 if_valid SHALL be low in the cycle after a redirect.

Reset
REQ-021 On reset asserted (asynchronous): fetch_pc = RESET_VECTOR, FIFO empty, outstanding = 0, drop_count = 0, if_valid = 0, imem_req_valid = 0, misalign_fault = 0.
REQ-022 After reset deasserts, the first request SHALL issue at RESET_VECTOR on the first clock edge.
REQ-023 Reset mid-operation SHALL discard all state; responses to pre-reset requests are the environment's responsibility not to return.

Configuration
REQ-024 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_target[1:0] != 0 SHALL pulse misalign_fault for one cycle, flush as REQ-016, and halt requests until the next aligned redirect.
REQ-025 Macro FETCH_MISALIGN_TRAP_EN undefined: redirect_target[1:0] SHALL be forced to 0; misalign_fault SHALL be tied to 0.

Verification
REQ-026 Reset release, imem_req_ready=1, 1-cycle response, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
REQ-027 if_ready=0, FIFO_DEPTH=4 -> exactly 4 requests issued, imem_req_valid low thereafter, FIFO full with PCs 0x0-0xC.
REQ-028 2 outstanding requests, redirect to 0x100 -> both responses discarded, next if_pc = 0x100.
REQ-029 Redirect at cycle N and another to 0x200 at N+1 with 3 outstanding -> no stale instruction on if_instr; first if_pc = 0x200.
REQ-030 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_fault one-cycle pulse, no requests until redirect to 0x104; without macro, fetch resumes at 0x100.
REQ-031 RESET_VECTOR=32'hFFFF_FFF8 -> fetch PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
